// File: rtl/i2c_bus_arbiter_pkg.sv
// i2c_bus_arbiter_pkg: I2C timing constants shared by the I2C clients and the master,
// the microsecond-to-cycle ceiling conversion, and the arbiter state type.
package i2c_bus_arbiter_pkg;
    localparam int T_BUF_US     = 5;
    localparam int T_TIMEOUT_US = 25000;
    typedef enum logic {IDLE, GRANTED} arb_state_e;
    function automatic int us_to_cycles(input longint freq_hz, input longint us);
        longint c;
        c = (freq_hz * us + 999_999) / 1_000_000;
        return (c < 1) ? 1 : int'(c);
    endfunction
endpackage

// File: rtl/i2c_round_robin.sv
// i2c_round_robin: combinational picker; searches pointer+1, pointer+2, ... modulo
// CLIENT_COUNT and returns the first asserted request.
module i2c_round_robin #(
    parameter int CLIENT_COUNT = 4,
    parameter int PW           = 2
)(
    input  logic [CLIENT_COUNT-1:0] request,
    input  logic [PW-1:0]           pointer,
    output logic                    found,
    output logic [PW-1:0]           index,
    output logic [CLIENT_COUNT-1:0] one_hot
);
    logic [PW-1:0] c;
    always_comb begin
        found = 1'b0;
        index = '0;
        c     = '0;
        for (int i = CLIENT_COUNT; i >= 1; i--) begin
            c = PW'((int'(pointer) + i) % CLIENT_COUNT);
            if (request[c]) begin
                found = 1'b1;
                index = c;
            end
        end
    end
    assign one_hot = found ? (CLIENT_COUNT'(1) << index) : '0;
endmodule

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin owner of a shared open-drain I2C pad pair with a
// bus-free guard time before each grant and an SCL-low watchdog on the owner.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 0,
    parameter int CLIENT_COUNT    = 4,
    parameter int BUS_FREE_US     = T_BUF_US,
    parameter int TIMEOUT_US      = T_TIMEOUT_US
)(
    input  logic                    clock,
    input  logic                    reset,
    input  logic [CLIENT_COUNT-1:0] request,
    output logic [CLIENT_COUNT-1:0] grant,
    input  logic [CLIENT_COUNT-1:0] client_scl_output,
    input  logic [CLIENT_COUNT-1:0] client_sda_output,
    input  logic                    scl_input,
    input  logic                    sda_input,
    output logic                    scl_output,
    output logic                    sda_output,
    output logic                    busy,
    output logic                    timeout
);
    localparam int FREE_CYCLES    = us_to_cycles(longint'(CLOCK_FREQUENCY), longint'(BUS_FREE_US));
    localparam int TIMEOUT_CYCLES = us_to_cycles(longint'(CLOCK_FREQUENCY), longint'(TIMEOUT_US));
    localparam int FW = $clog2(FREE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = (CLIENT_COUNT > 1) ? $clog2(CLIENT_COUNT) : 1;

    arb_state_e              state_q, state_d;
    logic [CLIENT_COUNT-1:0] grant_q, grant_d;
    logic [PW-1:0]           pointer_q, pointer_d;
    logic [FW-1:0]           free_q, free_d;
    logic [TW-1:0]           low_q, low_d;
    logic                    scl_q, scl_d, sda_q, sda_d, busy_q, timeout_q, timeout_d;
    logic                    found;
    logic [PW-1:0]           pick;
    logic [CLIENT_COUNT-1:0] pick_one_hot;

    i2c_round_robin #(.CLIENT_COUNT(CLIENT_COUNT), .PW(PW)) u_rr (
        .request (request),
        .pointer (pointer_q),
        .found   (found),
        .index   (pick),
        .one_hot (pick_one_hot)
    );

    // pointer_q doubles as the owner index while GRANTED
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        pointer_d = pointer_q;
        timeout_d = 1'b0;
        free_d    = (scl_input && sda_input) ? ((free_q == FW'(FREE_CYCLES)) ? free_q : free_q + 1'b1) : '0;
        low_d     = (state_q == GRANTED && !scl_input) ? ((low_q == TW'(TIMEOUT_CYCLES)) ? low_q : low_q + 1'b1) : '0;
        scl_d     = (state_q == GRANTED) ? client_scl_output[pointer_q] : 1'b1;
        sda_d     = (state_q == GRANTED) ? client_sda_output[pointer_q] : 1'b1;
        if (state_q == IDLE) begin
            grant_d = '0;
            if (free_q == FW'(FREE_CYCLES) && found) begin
                grant_d   = pick_one_hot;
                pointer_d = pick;
                state_d   = GRANTED;
            end
        end else if (!request[pointer_q]) begin
            grant_d = '0;
            state_d = IDLE;
        end else if (low_d == TW'(TIMEOUT_CYCLES)) begin
            grant_d   = '0;
            timeout_d = 1'b1;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            pointer_q <= PW'(CLIENT_COUNT - 1);
            free_q    <= '0;
            low_q     <= '0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            pointer_q <= pointer_d;
            free_q    <= free_d;
            low_q     <= low_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            busy_q    <= |grant_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant      = grant_q;
    assign scl_output = scl_q;
    assign sda_output = sda_q;
    assign busy       = busy_q;
    assign timeout    = timeout_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: table vectors, hand-written corner sequences and a randomized
// phase, all compared every cycle against an integer-level reference of the arbiter.
module tb_i2c_bus_arbiter;
    localparam int N    = 4;
    localparam int FREE = 5;
    localparam int TO   = 100;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] request = '0;
    logic [N-1:0] cscl = '1;
    logic [N-1:0] csda = '1;
    logic [N-1:0] grant;
    logic         scl_input, sda_input, scl_output, sda_output, busy, timeout;
    logic         ext_scl_low = 1'b0;
    logic         ext_sda_low = 1'b0;
    logic         chk_on = 1'b0;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clock = ~clock;

    // open-drain bus: pad drive wired-AND with external pull-downs
    assign scl_input = scl_output & ~ext_scl_low;
    assign sda_input = sda_output & ~ext_sda_low;

    i2c_bus_arbiter #(
        .CLOCK_FREQUENCY(1_000_000), .CLIENT_COUNT(N), .BUS_FREE_US(5), .TIMEOUT_US(100)
    ) dut (
        .clock(clock), .reset(reset), .request(request), .grant(grant),
        .client_scl_output(cscl), .client_sda_output(csda),
        .scl_input(scl_input), .sda_input(sda_input),
        .scl_output(scl_output), .sda_output(sda_output),
        .busy(busy), .timeout(timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int owner;
        int last;
        int high;
        int low;
        bit scl;
        bit sda;
        bit tmo;
    } model_t;

    model_t m = '{owner: -1, last: N-1, high: 0, low: 0, scl: 1'b1, sda: 1'b1, tmo: 1'b0};

    function automatic model_t model_next(model_t c, logic rst, logic [N-1:0] req,
                                          logic [N-1:0] cs, logic [N-1:0] cd, logic si, logic di);
        model_t n = c;
        n.tmo = 1'b0;
        if (rst) begin
            n.owner = -1; n.last = N-1; n.high = 0; n.low = 0; n.scl = 1'b1; n.sda = 1'b1;
            return n;
        end
        n.high = (si && di) ? ((c.high < FREE) ? c.high + 1 : FREE) : 0;
        n.low  = (c.owner >= 0 && !si) ? ((c.low < TO) ? c.low + 1 : TO) : 0;
        n.scl  = (c.owner >= 0) ? cs[c.owner] : 1'b1;
        n.sda  = (c.owner >= 0) ? cd[c.owner] : 1'b1;
        if (c.owner < 0) begin
            if (c.high == FREE)
                for (int k = 1; k <= N; k++)
                    if (req[(c.last + k) % N]) begin
                        n.owner = (c.last + k) % N;
                        n.last  = n.owner;
                        break;
                    end
        end else if (!req[c.owner]) begin
            n.owner = -1;
        end else if (n.low == TO) begin
            n.owner = -1;
            n.tmo   = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clock) m <= model_next(m, reset, request, cscl, csda, scl_input, sda_input);

    always @(negedge clock) if (chk_on) begin
        check("model grant", 32'(grant), (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0);
        check("model busy", 32'(busy), 32'(m.owner >= 0));
        check("model timeout", 32'(timeout), 32'(m.tmo));
        check("model scl", 32'(scl_output), 32'(m.scl));
        check("model sda", 32'(sda_output), 32'(m.sda));
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; request = '0; cscl = '1; csda = '1; ext_scl_low = 1'b0; ext_sda_low = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output int idx, output int idle);
        idx = -1;
        idle = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (grant != 0) begin
                for (int k = 0; k < N; k++) if (grant[k]) idx = k;
                break;
            end
            idle++;
        end
        check("grant within budget", 32'(idx >= 0), 32'd1);
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] exp;
    } vec_t;

    vec_t vecs[5];
    int   rr_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int  g, idle, cnt;
        logic prev;
        logic stuck;
        vecs = '{'{4'b0001, 4'b0001}, '{4'b0100, 4'b0100}, '{4'b1010, 4'b0010},
                 '{4'b1000, 4'b1000}, '{4'b0000, 4'b0000}};
        do_reset();
        chk_on = 1'b1;

        // first grant lands FREE+1 cycles after reset, client 0 side of pointer first
        foreach (vecs[i]) begin
            do_reset();
            request = vecs[i].req;
            check("reset grant", 32'(grant), 32'd0);
            check("reset scl", 32'(scl_output), 32'd1);
            repeat (FREE) begin
                @(negedge clock);
                check("guard grant", 32'(grant), 32'd0);
            end
            @(negedge clock);
            check("first grant", 32'(grant), 32'(vecs[i].exp));
            check("first busy", 32'(busy), 32'(|vecs[i].exp));
        end

        // round robin with owners holding SDA low during their transfers
        do_reset();
        request = '1;
        for (int i = 0; i < 5; i++) begin
            wait_grant(200, g, idle);
            if (g < 0) break;
            if (i > 0) check("rr idle gap", 32'(idle + 1 >= FREE), 32'd1);
            check("rr order", 32'(g), 32'(rr_order[i]));
            csda[g] = 1'b0;
            repeat (20) @(negedge clock);
            csda[g] = 1'b1;
            request[g] = 1'b0;
            @(negedge clock);
            check("rr release", 32'(grant), 32'd0);
            request[g] = 1'b1;
        end

        // drive isolation: non-owner SDA ignored, owner SCL forwarded one cycle later
        do_reset();
        request = 4'b0100;
        wait_grant(20, g, idle);
        check("iso owner", 32'(g), 32'd2);
        csda[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cscl[2] = 1'($urandom_range(0, 1));
            prev = cscl[2];
            @(negedge clock);
            check("iso scl follows", 32'(scl_output), 32'(prev));
            check("iso sda held", 32'(sda_output), 32'd1);
        end
        cscl = '1; csda = '1; request = '0;

        // watchdog: owner 1 stuck low, client 3 served before client 1 again
        do_reset();
        request = 4'b1010;
        wait_grant(20, g, idle);
        check("wdog owner", 32'(g), 32'd1);
        cscl[1] = 1'b0;
        cnt = 0;
        while (scl_input !== 1'b0 && cnt < 5) begin @(negedge clock); cnt++; end
        cnt = 0;
        while (timeout !== 1'b1 && cnt < 150) begin @(negedge clock); cnt++; end
        check("wdog latency", 32'(cnt), 32'(TO));
        check("wdog grant", 32'(grant), 32'd0);
        check("wdog busy", 32'(busy), 32'd0);
        cscl[1] = 1'b1;
        @(negedge clock);
        check("wdog pulse width", 32'(timeout), 32'd0);
        check("wdog scl released", 32'(scl_output), 32'd1);
        check("wdog sda released", 32'(sda_output), 32'd1);
        wait_grant(50, g, idle);
        check("wdog next owner", 32'(g), 32'd3);
        request = '0;

        // SDA glitch 3 cycles into the guard restarts the count
        do_reset();
        request = 4'b0001;
        repeat (3) @(negedge clock);
        ext_sda_low = 1'b1;
        @(negedge clock);
        ext_sda_low = 1'b0;
        repeat (FREE) begin
            @(negedge clock);
            check("glitch guard", 32'(grant), 32'd0);
        end
        @(negedge clock);
        check("glitch grant", 32'(grant), 32'd1);

        // reset mid-transfer
        do_reset();
        request = 4'b0011;
        wait_grant(20, g, idle);
        check("mid owner", 32'(g), 32'd0);
        cscl[0] = 1'b0;
        repeat (3) @(negedge clock);
        check("mid scl low", 32'(scl_output), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cscl[0] = 1'b1;
        check("mid reset grant", 32'(grant), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset scl", 32'(scl_output), 32'd1);
        check("mid reset sda", 32'(sda_output), 32'd1);
        wait_grant(30, g, idle);
        check("mid regrant", 32'(g), 32'd0);

        // randomized traffic against the reference
        do_reset();
        stuck = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            reset = ($urandom_range(0, 999) == 0);
            for (int k = 0; k < N; k++) if ($urandom_range(0, 15) == 0) request[k] = ~request[k];
            if ($urandom_range(0, 149) == 0) stuck = ~stuck;
            cscl = stuck ? '0 : (($urandom_range(0, 3) == 0) ? N'($urandom) : '1);
            csda = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            ext_scl_low = ($urandom_range(0, 63) == 0);
            ext_sda_low = ($urandom_range(0, 31) == 0);
        end
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
